// File: rtl/c17_bist_pkg.sv
// rtl/c17_bist_pkg.sv - shared types and defaults for the c17 BIST response path
package c17_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } c17_state_e;

    localparam logic [7:0] C17_MISR_POLY = 8'h1D;
    localparam logic [7:0] C17_MISR_SEED = 8'hFF;
    localparam int         C17_NUM_OUT   = 2;

endpackage

// File: rtl/misr_core.sv
// rtl/misr_core.sv - Galois-form multiple-input signature register
module misr_core
    import c17_bist_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(C17_MISR_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(C17_MISR_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_next
);

    // sig_next is exported so the caller can compare the value being written
    always_comb begin
        sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/c17_misr_compactor.sv
// rtl/c17_misr_compactor.sv - c17 output compactor with run control and signature compare
module c17_misr_compactor
    import c17_bist_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(C17_MISR_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(C17_MISR_SEED),
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic             in_valid,
    input  logic             G22,
    input  logic             G23,
    input  logic [WIDTH-1:0] expected,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    c17_state_e       state, state_next;
    logic [CNT_W-1:0] n_latch;
    logic [CNT_W-1:0] count_inc;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] sig_next;
    logic             accept_start;
    logic             accept_pat;
    logic             last_pat;

    always_comb begin
        din                  = '0;
        din[C17_NUM_OUT-2]   = G22;
        din[C17_NUM_OUT-1]   = G23;
    end

    assign count_inc    = count + CNT_ONE;
    assign accept_start = start && (state != RUN);
    assign accept_pat   = (state == RUN) && in_valid;
    assign last_pat     = accept_pat && (count_inc == n_latch);

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_start),
        .en       (accept_pat),
        .din      (din),
        .sig      (signature),
        .sig_next (sig_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (num_patterns == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_pat) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // An empty run finishes immediately, so the seed itself is the signature
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            n_latch <= '0;
            pass    <= 1'b0;
        end else if (accept_start) begin
            count   <= '0;
            n_latch <= num_patterns;
            pass    <= (num_patterns == '0) ? (SEED == expected) : 1'b0;
        end else if (accept_pat) begin
            count <= count_inc;
            if (last_pat) begin
                pass <= (sig_next == expected);
            end
        end
    end

endmodule

// File: tb/tb_c17_misr_compactor.sv
// tb/tb_c17_misr_compactor.sv - randomized and directed checks of the c17 compactor against a reference model
module tb_c17_misr_compactor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_patterns = 8'd0;
    logic       in_valid = 1'b0;
    logic       G22 = 1'b0;
    logic       G23 = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       busy, done, pass;
    logic [7:0] signature;
    logic [7:0] count;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // reference state: mode 0 idle, 1 running, 2 finished
    int m_mode   = 0;
    int m_sig    = 'hFF;
    int m_cnt    = 0;
    int m_target = 0;
    int m_pass   = 0;

    c17_misr_compactor dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .in_valid     (in_valid),
        .G22          (G22),
        .G23          (G23),
        .expected     (expected),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .count        (count)
    );

    always #5 clk = ~clk;

    // one signature step as polynomial arithmetic: multiply by x mod (x^8 + 0x1D), add inputs
    function automatic int fold(input int s, input int g22, input int g23);
        int v;
        v = s * 2;
        if (v >= 256) v = (v - 256) ^ 'h1D;
        return v ^ (g23 * 2 + g22);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode   <= 0;
            m_sig    <= 'hFF;
            m_cnt    <= 0;
            m_target <= 0;
            m_pass   <= 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_sig    <= 'hFF;
                m_cnt    <= 0;
                m_target <= int'(num_patterns);
                if (num_patterns == 0) begin
                    m_mode <= 2;
                    m_pass <= int'(expected == 8'hFF);
                end else begin
                    m_mode <= 1;
                end
            end
        end else if (in_valid) begin
            m_sig <= fold(m_sig, int'(G22), int'(G23));
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_target) begin
                m_mode <= 2;
                m_pass <= int'(fold(m_sig, int'(G22), int'(G23)) == int'(expected));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(m_mode == 1));
            check("done", int'(done), int'(m_mode == 2));
            check("signature", int'(signature), m_sig);
            check("count", int'(count), m_cnt);
            if (m_mode == 2) check("pass", int'(pass), m_pass);
        end
    end

    task automatic cyc(input logic s, input logic [7:0] np, input logic v,
                       input logic g23, input logic g22);
        start        = s;
        num_patterns = np;
        in_valid     = v;
        G22          = g22;
        G23          = g23;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run3(input logic [7:0] exp_val, input int gap1, input int gap2);
        expected = exp_val;
        cyc(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        check("sig_p1", int'(signature), 'hE2);
        idle(gap1);
        check("sig_gap1", int'(signature), 'hE2);
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
        check("sig_p2", int'(signature), 'hDA);
        idle(gap2);
        check("cnt_gap2", int'(count), 2);
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        check("sig_p3", int'(signature), 'hAB);
        check("model_p3", m_sig, 'hAB);
        check("done_p3", int'(done), 1);
        check("pass_p3", int'(pass), int'(exp_val == 8'hAB));
    endtask

    initial begin
        logic [7:0] np;
        int         nxt;
        idle(2);
        check("rst_sig", int'(signature), 'hFF);
        check("rst_cnt", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(1);

        run3(8'hAB, 0, 0);
        run3(8'hAC, 0, 0);
        run3(8'hAB, 1, 3);

        expected = 8'hFF;
        cyc(1'b1, 8'd0, 1'b1, 1'b1, 1'b1);
        check("zero_done", int'(done), 1);
        check("zero_sig", int'(signature), 'hFF);
        check("zero_pass", int'(pass), 1);
        expected = 8'h12;
        cyc(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        check("zero_fail", int'(pass), 0);

        // in_valid in DONE, start mid-RUN, then restart from DONE
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
        check("done_ignore", int'(signature), 'hFF);
        cyc(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
        check("start_in_run", int'(count), 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 8'd9, 1'b1, 1'b1, 1'b1);
        check("run2_done", int'(done), 1);
        cyc(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        check("restart_sig", int'(signature), 'hFF);
        check("restart_cnt", int'(count), 0);
        expected = 8'hE3;
        cyc(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        check("msb_sig", int'(signature), 'hE3);
        check("msb_pass", int'(pass), 1);

        // asynchronous reset in the middle of a run
        cyc(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        check("pre_rst_cnt", int'(count), 2);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_sig", int'(signature), 'hFF);
        check("arst_cnt", int'(count), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 2000; i++) begin
            np = 8'($urandom_range(0, 6));
            nxt = fold(m_sig, 0, 0);
            start    = ($urandom_range(0, 7) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            G22      = $urandom_range(0, 1) == 1;
            G23      = $urandom_range(0, 1) == 1;
            nxt = fold(m_sig, int'(G22), int'(G23));
            if ($urandom_range(0, 1) == 1) expected = 8'(nxt);
            else if ($urandom_range(0, 3) == 0) expected = 8'hFF;
            else expected = 8'($urandom);
            num_patterns = np;
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/c17_misr_compactor.md
Name: c17_misr_compactor

Overview:
- Downstream response compactor for the c17 combinational netlist in our BIST flow.
- Consumes the c17 primary outputs G22 and G23 once per applied pattern.
- Folds them into a multiple-input signature register (MISR) over a programmed number of patterns, then compares the final signature against an expected value.
- Reports busy, done and pass/fail to the BIST controller.

Parameters:
- WIDTH, 8, signature register width in bits; must be ≥ 2.
- POLY, 8'h1D, feedback tap mask, XORed in when the shifted-out MSB is 1 (Galois form).
- SEED, 8'hFF, signature value loaded at reset and on every start.
- CNT_W, 8, width of the pattern counter and of num_patterns.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a compaction run.
- num_patterns  input  CNT_W  number of valid patterns to compact; sampled on an accepted start.
- in_valid  input  1  G22/G23 carry a valid c17 response this cycle.
- G22  input  1  c17 output G22.
- G23  input  1  c17 output G23.
- expected  input  WIDTH  golden signature; compared when the run finishes.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- pass  output  1  result of the final signature compare; valid only while done=1.
- signature  output  WIDTH  current MISR contents.
- count  output  CNT_W  number of patterns accepted in the current run.

Behaviour:
- Reset (asynchronous, active-high, takes effect mid-operation): state=IDLE, signature=SEED, count=0, busy=0, done=0, pass=0. The internal num_patterns latch is cleared to 0.
- FSM states are IDLE, RUN and DONE. All outputs are registered.
- IDLE, start=1:
  - signature<=SEED, count<=0, latch num_patterns.
  - If num_patterns==0: next state DONE, pass<=(SEED==expected).
  - Otherwise: next state RUN.
  - in_valid is ignored in IDLE, including a cycle where start=1.
- RUN, in_valid=1 (MISR update, one cycle latency):
  - sig_next = (sig<<1, truncated to WIDTH) ^ (sig[WIDTH-1] ? POLY : 0) ^ {0…0, G23, G22}.
  - G22 feeds bit 0; G23 feeds bit 1.
  - count<=count+1.
- RUN, in_valid=0: signature and count hold. Gaps between patterns are legal.
- RUN, last pattern: when in_valid=1 and count+1 == latched num_patterns:
  - next state DONE.
  - pass<=(sig_next==expected); the compare uses the value being written.
- RUN, start=1: ignored; no restart and no relatch of num_patterns.
- DONE:
  - signature, count and pass hold; done=1.
  - in_valid is ignored.
  - start=1 behaves exactly as start in IDLE (restart; num_patterns==0 handling included).
- Other rules:
  - expected is not latched. It must be stable in the cycle the run finishes.
  - The counter cannot wrap, because the run ends at num_patterns ≤ 2^CNT_W−1.

Decomposition:
- Shared package c17_bist_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - defaults C17_MISR_POLY=8'h1D and C17_MISR_SEED=8'hFF;
  - the c17 output count constant C17_NUM_OUT=2.
- One natural sub-module, misr_core: a parameterised WIDTH/POLY Galois MISR with load, enable and a data input.
- The FSM and counter stay in the top level.

Test Plan:
- Reset during RUN (count=2): signature returns to 8'hFF, count=0, busy=0, done=0 asynchronously, before the next clock edge.
- start, num_patterns=3, then valid (G23,G22) = (0,1), (1,1), (1,0) on three cycles:
  - signature goes 8'hE2 → 8'hDA → 8'hAB;
  - done=1 the cycle after the third pattern;
  - with expected=8'hAB: pass=1; with expected=8'hAC: pass=0.
- Same three patterns with in_valid=0 gaps of 1 and 3 cycles between them:
  - signature and count frozen during the gaps;
  - final signature 8'hAB;
  - busy=1 throughout the run.
- start with num_patterns=0: next cycle done=1, signature=8'hFF, count=0; pass=1 only when expected=8'hFF.
- start pulsed mid-RUN and in_valid pulsed in IDLE/DONE: no effect on signature or count. Then start in DONE restarts with signature=8'hFF and count=0.
- MSB feedback check, num_patterns=1, input (0,0) from seed: signature=8'hE3 (8'hFE^8'h1D).
